// File: rtl/coax_rx_frame_buffer_pkg.sv
// rtl/coax_rx_frame_buffer_pkg.sv - shared entry layout and FSM encodings for the coax_rx frame buffer
//
// Purpose: one place for the 12-bit FIFO entry layout {eof, err, data[9:0]}
//          and the frame FSM state encodings used by coax_rx_frame_buffer.
package coax_rx_frame_buffer_pkg;

  localparam int ENTRY_WIDTH   = 12;
  localparam int ENTRY_EOF_BIT = 11;
  localparam int ENTRY_ERR_BIT = 10;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_RECEIVE     = 2'd1;
  localparam logic [1:0] ST_ERROR_FLUSH = 2'd2;
  localparam logic [1:0] ST_DISCARD     = 2'd3;

  function automatic logic [ENTRY_WIDTH-1:0] make_entry(input logic eof, input logic err,
                                                        input logic [9:0] data);
    logic [ENTRY_WIDTH-1:0] e;
    e                = '0;
    e[ENTRY_EOF_BIT] = eof;
    e[ENTRY_ERR_BIT] = err;
    e[9:0]           = data;
    return e;
  endfunction

endpackage

// File: rtl/coax_fifo.sv
// rtl/coax_fifo.sv - single-clock show-ahead FIFO for coax_rx frame entries
//
// Purpose: synchronous FIFO whose head entry is always presented on pop_data_o.
// Ports:
//   clk, reset           clock, synchronous active-high reset (empties the FIFO)
//   push_i, push_data_i  write request and entry; ignored when full unless a pop frees a slot
//   pop_i                remove head entry (ignored when empty)
//   pop_data_o           head entry, forced to zero while empty
//   full_o, empty_o      occupancy flags
module coax_fifo
  import coax_rx_frame_buffer_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH      = ENTRY_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_q, rd_ptr_q;
  logic                do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  // A same-cycle pop frees the slot the push is about to use.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/coax_rx_frame_buffer.sv
// rtl/coax_rx_frame_buffer.sv - groups coax_rx words into EOF/error-tagged frames and queues them for the host
//
// Purpose: registers the coax_rx strobe interface, stages the most recent word so
//          the frame's last word can carry EOF, turns receiver errors into tagged
//          entries and drops the rest of a frame when the FIFO runs out of space.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   rx_active, rx_strobe,
//   rx_data, rx_error           coax_rx word interface (rx_data is the error code while rx_error=1)
//   rd_data, rd_valid, rd_ready show-ahead head entry {eof, err, data}, pop handshake
//   full                        FIFO full
//   overflow, overflow_clear    sticky frame-dropped flag and its clear (clear wins)
//   frame_count, drop_count     only with COAX_RX_FRAME_BUFFER_STATS_EN: saturating EOF / overflow counters
module coax_rx_frame_buffer
  import coax_rx_frame_buffer_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_active,
  input  logic        rx_strobe,
  input  logic [9:0]  rx_data,
  input  logic        rx_error,
  output logic [11:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        full,
  output logic        overflow,
  input  logic        overflow_clear
`ifdef COAX_RX_FRAME_BUFFER_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count
`endif
);

  logic                   act_q, stb_q, err_q, armed_q;
  logic [9:0]             data_q;
  logic [1:0]             state_q, state_d;
  logic                   staged_q, staged_d;
  logic [9:0]             stage_data_q, stage_data_d;
  logic [9:0]             err_code_q, err_code_d;
  logic                   overflow_q;
  logic                   push_req, push_ok, drop;
  logic                   fifo_full, fifo_empty;
  logic [ENTRY_WIDTH-1:0] push_entry;

  assign push_ok = !fifo_full || (rd_ready && !fifo_empty);
  assign drop    = push_req && !push_ok;

  always_comb begin
    state_d      = state_q;
    staged_d     = staged_q;
    stage_data_d = stage_data_q;
    err_code_d   = err_code_q;
    push_req     = 1'b0;
    push_entry   = '0;
    case (state_q)
      // armed_q is low until rx_active has been seen low after reset, so a frame
      // already running at reset release is discarded rather than captured mid-way.
      ST_IDLE: begin
        if (act_q) state_d = armed_q ? ST_RECEIVE : ST_DISCARD;
      end
      ST_RECEIVE: begin
        if (err_q) begin
          push_req = 1'b1;
          staged_d = 1'b0;
          if (staged_q) begin
            push_entry = make_entry(1'b0, 1'b0, stage_data_q);
            err_code_d = data_q;
            state_d    = ST_ERROR_FLUSH;
          end else begin
            push_entry = make_entry(1'b1, 1'b1, data_q);
            state_d    = ST_DISCARD;
          end
        end else if (!act_q) begin
          push_req   = staged_q;
          push_entry = make_entry(1'b1, 1'b0, stage_data_q);
          staged_d   = 1'b0;
          state_d    = ST_IDLE;
        end else if (stb_q) begin
          push_req     = staged_q;
          push_entry   = make_entry(1'b0, 1'b0, stage_data_q);
          staged_d     = 1'b1;
          stage_data_d = data_q;
        end
      end
      ST_ERROR_FLUSH: begin
        push_req   = 1'b1;
        push_entry = make_entry(1'b1, 1'b1, err_code_q);
        state_d    = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (!act_q && !err_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // No room: abandon the rest of the frame; entries already queued stay.
    if (drop) begin
      staged_d = 1'b0;
      state_d  = ST_DISCARD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_q        <= 1'b0;
      stb_q        <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
      armed_q      <= 1'b0;
      state_q      <= ST_IDLE;
      staged_q     <= 1'b0;
      stage_data_q <= '0;
      err_code_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      act_q        <= rx_active;
      stb_q        <= rx_strobe;
      err_q        <= rx_error;
      data_q       <= rx_data;
      armed_q      <= armed_q | ~rx_active;
      state_q      <= state_d;
      staged_q     <= staged_d;
      stage_data_q <= stage_data_d;
      err_code_q   <= err_code_d;
      if (overflow_clear)  overflow_q <= 1'b0;
      else if (drop)       overflow_q <= 1'b1;
    end
  end

  coax_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (ENTRY_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_req),
    .push_data_i (push_entry),
    .pop_i       (rd_ready),
    .pop_data_o  (rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rd_valid = !fifo_empty;
  assign full     = fifo_full;
  assign overflow = overflow_q;

`ifdef COAX_RX_FRAME_BUFFER_STATS_EN
  logic [15:0] frame_count_q, drop_count_q;
  logic        eof_written;

  assign eof_written = push_req && push_ok && push_entry[ENTRY_EOF_BIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      if (eof_written && frame_count_q != 16'hFFFF) frame_count_q <= frame_count_q + 16'd1;
      if (drop && drop_count_q != 16'hFFFF)         drop_count_q  <= drop_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_coax_rx_frame_buffer.sv
// tb/tb_coax_rx_frame_buffer.sv - self-checking bench for coax_rx_frame_buffer (DEPTH=4)
`timescale 1ns/1ps
module tb_coax_rx_frame_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, rx_active, rx_strobe, rx_error, rd_ready, overflow_clear;
  logic [9:0]  rx_data;
  logic [11:0] rd_data;
  logic        rd_valid, full, overflow;
`ifdef COAX_RX_FRAME_BUFFER_STATS_EN
  logic [15:0] frame_count, drop_count;
`endif

  always #5 clk = ~clk;

  coax_rx_frame_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_active      (rx_active),
    .rx_strobe      (rx_strobe),
    .rx_data        (rx_data),
    .rx_error       (rx_error),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .full           (full),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
`ifdef COAX_RX_FRAME_BUFFER_STATS_EN
    ,
    .frame_count    (frame_count),
    .drop_count     (drop_count)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] exp_q[$];
  logic [9:0]  cur_words[$];
  logic        exp_ovf;
  int          exp_frames, exp_drops;
  bit          frame_dead;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: FIFO is a queue of capacity DEPTH; the first entry that finds it full
  // is lost, sets overflow and ends the frame's contribution.
  task automatic model_push(input logic eof, input logic err, input logic [9:0] d);
    if (frame_dead) return;
    if (exp_q.size() >= DEPTH) begin
      exp_ovf    = 1'b1;
      exp_drops++;
      frame_dead = 1'b1;
    end else begin
      exp_q.push_back({eof, err, d});
      if (eof) exp_frames++;
    end
  endtask

  // A frame is its words in order; the last carries EOF unless an error cut it short,
  // in which case the words before the error are followed by one {eof,err,code} entry.
  task automatic model_frame(input int err_at, input logic [9:0] code);
    frame_dead = 1'b0;
    if (err_at >= 0) begin
      for (int i = 0; i < err_at; i++) model_push(1'b0, 1'b0, cur_words[i]);
      model_push(1'b1, 1'b1, code);
    end else begin
      for (int i = 0; i < cur_words.size(); i++)
        model_push(i == cur_words.size() - 1, 1'b0, cur_words[i]);
    end
  endtask

  task automatic drive_frame(input int err_at, input logic [9:0] code, input bit pop_at_end);
    rx_active = 1'b1;
    repeat (1 + $urandom_range(0, 1)) @(negedge clk);
    for (int i = 0; i < cur_words.size(); i++) begin
      if (i == err_at) break;
      rx_data   = cur_words[i];
      rx_strobe = 1'b1;
      @(negedge clk);
      rx_strobe = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (err_at >= 0) begin
      rx_data  = code;
      rx_error = 1'b1;
      repeat (2) @(negedge clk);
      rx_strobe = 1'b1;
      @(negedge clk);
      rx_strobe = 1'b0;
      @(negedge clk);
    end
    rx_active = 1'b0;
    @(negedge clk);
    if (pop_at_end) begin
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
    rx_error = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain_and_check(input string tag);
    int n;
    n = exp_q.size();
    check_eq({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check_eq({tag, "_full"}, {31'd0, full}, {31'd0, logic'(n == DEPTH)});
`ifdef COAX_RX_FRAME_BUFFER_STATS_EN
    check_eq({tag, "_frame_count"}, {16'd0, frame_count}, exp_frames);
    check_eq({tag, "_drop_count"}, {16'd0, drop_count}, exp_drops);
`endif
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
      check_eq({tag, "_data"}, {20'd0, rd_data}, {20'd0, exp_q[i]});
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
    end
    exp_q.delete();
    check_eq({tag, "_empty_valid"}, {31'd0, rd_valid}, 32'd0);
    if (exp_ovf) begin
      overflow_clear = 1'b1;
      @(negedge clk);
      overflow_clear = 1'b0;
      exp_ovf = 1'b0;
      check_eq({tag, "_ovf_clear"}, {31'd0, overflow}, 32'd0);
    end
  endtask

  task automatic do_reset(input logic active_during);
    reset     = 1'b1;
    rx_active = active_during;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    exp_ovf    = 1'b0;
    exp_frames = 0;
    exp_drops  = 0;
  endtask

  initial begin
    rx_strobe = 1'b0; rx_error = 1'b0; rx_data = '0;
    rd_ready = 1'b0; overflow_clear = 1'b0;
    do_reset(1'b0);
    check_eq("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("reset_rd_data", {20'd0, rd_data}, 32'd0);
    check_eq("reset_full", {31'd0, full}, 32'd0);
    check_eq("reset_overflow", {31'd0, overflow}, 32'd0);

    // Three-word frame: EOF only on the last entry.
    cur_words = '{10'h00A, 10'h155, 10'h2AA};
    drive_frame(-1, 10'h0, 1'b0);
    check_eq("three_word_valid_before_pop", {31'd0, rd_valid}, 32'd1);
    exp_q = '{12'h00A, 12'h155, 12'hAAA}; exp_frames += 1;
    drain_and_check("three_word");

    cur_words = '{10'h00A};
    drive_frame(-1, 10'h0, 1'b0);
    exp_q = '{12'h80A}; exp_frames += 1;
    drain_and_check("single_word");

    cur_words = '{10'h001, 10'h002};
    drive_frame(2, 10'h004, 1'b0);
    exp_q = '{12'h001, 12'h002, 12'hC04}; exp_frames += 1;
    drain_and_check("error_frame");

    // Six words into four slots: word 4 is the first push that finds the FIFO full.
    cur_words = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h015};
    drive_frame(-1, 10'h0, 1'b0);
    exp_q = '{12'h010, 12'h011, 12'h012, 12'h013}; exp_ovf = 1'b1; exp_drops += 1;
    drain_and_check("overflow_frame");

    // Frame in progress across reset release must be discarded entirely.
    do_reset(1'b1);
    repeat (2) begin
      rx_data = 10'h3FF; rx_strobe = 1'b1; @(negedge clk);
      rx_strobe = 1'b0; @(negedge clk);
    end
    rx_active = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("partial_after_reset_valid", {31'd0, rd_valid}, 32'd0);
    cur_words = '{10'h123, 10'h321};
    drive_frame(-1, 10'h0, 1'b0);
    exp_q = '{12'h123, 12'hB21}; exp_frames += 1;
    drain_and_check("after_partial");

    // Fill exactly, then land the next frame's only push on a cycle that also pops.
    cur_words = '{10'h0A1, 10'h0A2, 10'h0A3, 10'h0A4};
    drive_frame(-1, 10'h0, 1'b0);
    check_eq("filled_full", {31'd0, full}, 32'd1);
    cur_words = '{10'h0B5};
    drive_frame(-1, 10'h0, 1'b1);
    check_eq("push_pop_full_overflow", {31'd0, overflow}, 32'd0);
    check_eq("push_pop_full_full", {31'd0, full}, 32'd1);
    exp_q = '{12'h0A2, 12'h0A3, 12'h8A4, 12'h8B5}; exp_frames += 2;
    drain_and_check("push_pop_full");

    for (int f = 0; f < 40; f++) begin
      int          len, err_at;
      logic [9:0]  code;
      len = $urandom_range(0, 6);
      cur_words.delete();
      for (int i = 0; i < len; i++) cur_words.push_back(10'($urandom_range(0, 1023)));
      err_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      code   = 10'($urandom_range(0, 1023));
      model_frame(err_at, code);
      drive_frame(err_at, code, 1'b0);
      drain_and_check("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
